// File: rtl/tpuv2.sv
// tpuv2: matrix-multiply top; memA/memB feed a DIM x DIM output-stationary systolic array
// under an IDLE/CLEAR/RUN/DONE sequencer with accumulate mode and host write gating.

module tpuv2_mem #(
    parameter int BITS = 8,
    parameter int DIM  = 8,
    parameter int CW   = 5,
    parameter bit COLS = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we,
    input  logic [$clog2(DIM)-1:0]       row,
    input  logic [$clog2(DIM)-1:0]       col,
    input  logic [BITS-1:0]              din,
    input  logic [CW-1:0]                cyc,
    output logic [DIM-1:0][BITS-1:0]     feed
);
    localparam int AW = $clog2(DIM);
    logic [DIM-1:0][DIM-1:0][BITS-1:0] m;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else if (we) m[row][col] <= din;
    end
    // Lane l presents element k = cyc - l, giving the diagonal skew without destroying storage
    for (genvar l = 0; l < DIM; l++) begin : g_l
        logic [CW-1:0] k;
        logic [AW-1:0] ki;
        assign k = cyc - CW'(l);
        assign ki = k[AW-1:0];
        assign feed[l] = (cyc >= CW'(l) && k < CW'(DIM)) ? (COLS ? m[ki][l] : m[l][ki]) : '0;
    end
endmodule

module tpuv2_array #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int DIM     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          we,
    input  logic [$clog2(DIM)-1:0]        wrow,
    input  logic [$clog2(DIM)-1:0]        wcol,
    input  logic [BITS_C-1:0]             cin,
    input  logic [$clog2(DIM)-1:0]        rrow,
    input  logic [$clog2(DIM)-1:0]        rcol,
    input  logic [DIM-1:0][BITS_AB-1:0]   a_in,
    input  logic [DIM-1:0][BITS_AB-1:0]   b_in,
    output logic [BITS_C-1:0]             cout
);
    logic [DIM-1:0][DIM-1:0][BITS_AB-1:0] a_pipe, b_pipe;
    logic [DIM-1:0][DIM-1:0][BITS_C-1:0]  c_acc;
    for (genvar i = 0; i < DIM; i++) begin : g_r
        assign a_pipe[i][0] = a_in[i];
        assign b_pipe[0][i] = b_in[i];
        for (genvar j = 0; j < DIM; j++) begin : g_c
            logic [BITS_C-1:0] c_r;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) c_r <= '0;
                else if (we && wrow == i && wcol == j) c_r <= cin;
                else if (en) c_r <= c_r + BITS_C'(a_pipe[i][j]) * BITS_C'(b_pipe[i][j]);
            end
            assign c_acc[i][j] = c_r;
            if (j < DIM - 1) begin : g_a
                logic [BITS_AB-1:0] a_r;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) a_r <= '0;
                    else if (en) a_r <= a_pipe[i][j];
                end
                assign a_pipe[i][j+1] = a_r;
            end
            if (i < DIM - 1) begin : g_b
                logic [BITS_AB-1:0] b_r;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) b_r <= '0;
                    else if (en) b_r <= b_pipe[i][j];
                end
                assign b_pipe[i+1][j] = b_r;
            end
        end
    end
    assign cout = c_acc[rrow][rcol];
endmodule

module tpuv2 #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int DIM     = 8,
    parameter int RUN_CYC = 3*DIM-1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    acc,
    input  logic                    WrEnA,
    input  logic                    WrEnB,
    input  logic                    WrEnC,
    input  logic [$clog2(DIM)-1:0]  row,
    input  logic [$clog2(DIM)-1:0]  col,
    input  logic [BITS_C-1:0]       dataIn,
    output logic [BITS_C-1:0]       dataOut,
    output logic                    busy,
    output logic                    done,
    output logic                    wr_blocked
);
    localparam int AW = $clog2(DIM);
    localparam int NW = 2*AW;
    localparam int CW = $clog2(RUN_CYC+1);
    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
    state_t state;
    logic [NW-1:0] cnt;
    logic [CW-1:0] cyc;
    logic idle, clr, en, we_c;
    logic [AW-1:0] c_row, c_col;
    logic [BITS_C-1:0] c_din;
    logic [DIM-1:0][BITS_AB-1:0] a_feed, b_feed;

    assign idle  = state == IDLE;
    assign clr   = state == CLEAR;
    assign en    = state == RUN;
    assign we_c  = clr | (idle & WrEnC);
    assign c_row = clr ? cnt[NW-1:AW] : row;
    assign c_col = clr ? cnt[AW-1:0] : col;
    assign c_din = clr ? '0 : dataIn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            cyc        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wr_blocked <= 1'b0;
        end else begin
            done       <= 1'b0;
            wr_blocked <= busy & (WrEnA | WrEnB | WrEnC);
            case (state)
                IDLE: if (start) begin
                    state <= acc ? RUN : CLEAR;
                    busy  <= 1'b1;
                end
                CLEAR: begin
                    cnt <= cnt + NW'(1);
                    if (&cnt) state <= RUN;
                end
                RUN: begin
                    cyc <= (cyc == CW'(RUN_CYC-1)) ? '0 : cyc + CW'(1);
                    if (cyc == CW'(RUN_CYC-1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    tpuv2_mem #(.BITS(BITS_AB), .DIM(DIM), .CW(CW), .COLS(1'b0)) mem_a (
        .clk(clk), .rst_n(rst_n), .we(idle & WrEnA), .row(row), .col(col),
        .din(dataIn[BITS_AB-1:0]), .cyc(cyc), .feed(a_feed)
    );
    tpuv2_mem #(.BITS(BITS_AB), .DIM(DIM), .CW(CW), .COLS(1'b1)) mem_b (
        .clk(clk), .rst_n(rst_n), .we(idle & WrEnB), .row(row), .col(col),
        .din(dataIn[BITS_AB-1:0]), .cyc(cyc), .feed(b_feed)
    );
    tpuv2_array #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .DIM(DIM)) array (
        .clk(clk), .rst_n(rst_n), .en(en), .we(we_c), .wrow(c_row), .wcol(c_col),
        .cin(c_din), .rrow(row), .rcol(col), .a_in(a_feed), .b_in(b_feed), .cout(dataOut)
    );
endmodule

// File: tb/tb_tpuv2.sv
// tb_tpuv2: directed and randomized passes of tpuv2 (DIM=4) checked against a
// plain matrix-arithmetic model of A, B and C.

module tb_tpuv2;
    localparam int DIM = 4;
    localparam int RC  = 3*DIM-1;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, acc = 1'b0;
    logic        WrEnA = 1'b0, WrEnB = 1'b0, WrEnC = 1'b0;
    logic [1:0]  row = '0, col = '0;
    logic [15:0] dataIn = '0;
    logic [15:0] dataOut;
    logic        busy, done, wr_blocked;

    int vectors = 0, miscompares = 0;
    int ma[DIM][DIM], mb[DIM][DIM], mc[DIM][DIM];

    tpuv2 #(.BITS_AB(8), .BITS_C(16), .DIM(DIM), .RUN_CYC(RC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .acc(acc),
        .WrEnA(WrEnA), .WrEnB(WrEnB), .WrEnC(WrEnC),
        .row(row), .col(col), .dataIn(dataIn), .dataOut(dataOut),
        .busy(busy), .done(done), .wr_blocked(wr_blocked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int sel, input int r, input int c, input int d);
        row = 2'(r); col = 2'(c); dataIn = 16'(d);
        WrEnA = (sel == 0); WrEnB = (sel == 1); WrEnC = (sel == 2);
        @(posedge clk); #1;
        WrEnA = 1'b0; WrEnB = 1'b0; WrEnC = 1'b0;
        if (sel == 0) ma[r][c] = d & 'hFF;
        if (sel == 1) mb[r][c] = d & 'hFF;
        if (sel == 2) mc[r][c] = d & 'hFFFF;
    endtask

    task automatic load_ab(input int kind);
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                case (kind)
                    0: begin ma[i][j] = (i == j); mb[i][j] = i*4 + j; end
                    1: begin ma[i][j] = 0; mb[i][j] = 0; end
                    2: begin ma[i][j] = 'h10; mb[i][j] = 'h10; end
                    default: begin ma[i][j] = $urandom_range(0, 255); mb[i][j] = $urandom_range(0, 255); end
                endcase
                wr(0, i, j, ma[i][j]);
                wr(1, i, j, mb[i][j]);
            end
    endtask

    task automatic fill_c(input int v);
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) wr(2, i, j, v);
    endtask

    task automatic model_pass(input bit a);
        int t;
        int nc[DIM][DIM];
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                t = 0;
                for (int k = 0; k < DIM; k++) t += ma[i][k] * mb[k][j];
                nc[i][j] = ((a ? mc[i][j] : 0) + t) & 'hFFFF;
            end
        mc = nc;
    endtask

    task automatic read_all(input string tag);
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                row = 2'(r); col = 2'(c); #1;
                check($sformatf("%s_c%0d%0d", tag, r, c), dataOut, mc[r][c]);
            end
    endtask

    // poke>0: at that observed cycle, fire a WrEnA+start that must be dropped
    task automatic run_pass(input string tag, input bit a, input int poke, input bit co_wr, input int co_val);
        int lat, dones, busyc, blk, blk_n, exp_lat;
        exp_lat = a ? RC + 1 : DIM*DIM + RC + 1;
        acc = a; start = 1'b1;
        if (co_wr) begin
            WrEnC = 1'b1; row = 2'd3; col = 2'd3; dataIn = 16'(co_val);
            mc[3][3] = co_val & 'hFFFF;
        end
        @(posedge clk); #1;
        start = 1'b0; WrEnC = 1'b0;
        lat = 0; dones = 0; busyc = 0; blk = 0; blk_n = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin dones++; lat = n; end
            if (busy === 1'b1) busyc++;
            if (wr_blocked === 1'b1) begin blk++; blk_n = n; end
            if (n == poke) begin
                WrEnA = 1'b1; row = 2'd1; col = 2'd2; dataIn = 16'h55; start = 1'b1;
            end else begin
                WrEnA = 1'b0; start = 1'b0;
            end
            if (busy !== 1'b1) break;
        end
        WrEnA = 1'b0; start = 1'b0;
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy_cycles"}, busyc, exp_lat);
        check({tag, "_done_pulses"}, dones, 1);
        if (poke > 0) begin
            check({tag, "_blocked_at"}, blk_n, poke + 1);
            check({tag, "_blocked_pulses"}, blk, 1);
        end else check({tag, "_blocked_pulses"}, blk, 0);
        model_pass(a);
    endtask

    initial begin
        int dn;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_blocked", wr_blocked, 0);
        check("rst_dataOut", dataOut, 0);
        check("rst_en", dut.en, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        foreach (mc[i, j]) mc[i][j] = 0;
        @(posedge clk); #1;

        load_ab(0);
        run_pass("ident", 1'b0, 0, 1'b0, 0);
        read_all("ident");
        run_pass("ident_acc", 1'b1, 0, 1'b0, 0);
        read_all("ident_acc");

        fill_c('h00FF);
        load_ab(1);
        run_pass("sweep", 1'b0, 0, 1'b0, 0);
        read_all("sweep");

        load_ab(3);
        run_pass("blocked", 1'b0, 20, 1'b0, 0);
        read_all("blocked");
        run_pass("blocked_acc", 1'b1, 0, 1'b0, 0);
        read_all("blocked_acc");

        fill_c('hFFFF);
        load_ab(2);
        run_pass("wrap", 1'b1, 0, 1'b0, 0);
        read_all("wrap");
        row = 2'd2; col = 2'd1; #1;
        check("wrap_value", dataOut, 16'h03FF);

        load_ab(3);
        run_pass("co_write", 1'b1, 0, 1'b1, $urandom_range(0, 65535));
        read_all("co_write");

        acc = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy", busy, 1);
        check("mid_en", dut.en, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_en", dut.en, 0);
        check("abort_done", done, 0);
        #9 rst_n = 1'b1;
        foreach (ma[i, j]) begin ma[i][j] = 0; mb[i][j] = 0; mc[i][j] = 0; end
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dn++;
        end
        check("abort_no_activity", dn, 0);
        read_all("abort");

        load_ab(3);
        run_pass("after_rst", 1'b0, 0, 1'b0, 0);
        read_all("after_rst");
        for (int p = 0; p < 3; p++) begin
            if (p == 1) load_ab(3);
            run_pass($sformatf("rand%0d", p), 1'($urandom_range(0, 1)), 0, 1'b0, 0);
            read_all($sformatf("rand%0d", p));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
